// File: rtl/multicycle_control.sv
// Multicycle controller for a small LEGv8-style datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, datapath control decode, memory-timeout fault and a retired-instruction counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic [3:0]  aluop,
  output logic [1:0]  signop,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [15:0] retired
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_LDUR, C_STUR, C_ADD, C_SUB, C_AND, C_ORR, C_CBZ, C_B, C_MOVZ
  } cls_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  function automatic cls_t classify(input logic [10:0] op);
    cls_t c;
    c = C_ILL;
    if      (op == 11'b11111000010)      c = C_LDUR;
    else if (op == 11'b11111000000)      c = C_STUR;
    else if (op == 11'b10001011000)      c = C_ADD;
    else if (op == 11'b11001011000)      c = C_SUB;
    else if (op == 11'b10001010000)      c = C_AND;
    else if (op == 11'b10101010000)      c = C_ORR;
    else if (op[10:3] == 8'b10110100)    c = C_CBZ;
    else if (op[10:5] == 6'b000101)      c = C_B;
    else if (op[10:2] == 9'b110100101)   c = C_MOVZ;
    return c;
  endfunction

  state_t         state_q, state_d;
  cls_t           cls_q, cls_d, cls_cur;
  logic [1:0]     fault_q, fault_d;
  logic [15:0]    retired_q, retired_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           in_exec, in_mem, is_br;

  // During DECODE the controls come straight from the opcode so they are valid
  // from DECODE onward; later states use the registered class.
  assign cls_cur = (state_q == S_DECODE) ? classify(opcode) : cls_q;
  assign in_exec = (state_q == S_EXEC);
  assign in_mem  = (state_q == S_MEM);
  assign is_br   = (cls_cur == C_CBZ) || (cls_cur == C_B);

  always_comb begin
    reg2loc = 1'b0;
    alusrc  = 1'b0;
    mem2reg = 1'b0;
    aluop   = ALU_ADD;
    signop  = 2'b00;
    case (cls_cur)
      C_LDUR: begin alusrc = 1'b1; mem2reg = 1'b1; signop = 2'b01; end
      C_STUR: begin reg2loc = 1'b1; alusrc = 1'b1; signop = 2'b01; end
      C_SUB:  aluop = ALU_SUB;
      C_AND:  aluop = ALU_AND;
      C_ORR:  aluop = ALU_ORR;
      C_CBZ:  begin reg2loc = 1'b1; aluop = ALU_PASSB; signop = 2'b11; end
      C_B:    signop = 2'b10;
      C_MOVZ: begin alusrc = 1'b1; aluop = ALU_PASSB; end
      default: ;
    endcase
  end

  assign irwrite  = (state_q == S_FETCH);
  assign regwrite = (state_q == S_WB);
  assign memread  = in_mem && (cls_cur == C_LDUR) && !resetl;
  // Store strobe is gated by reset so a reset landing mid-store never writes.
  assign memwrite = in_mem && (cls_cur == C_STUR) && !resetl;
  assign pcwrite  = (in_exec && is_br)
                 || (in_mem && (cls_cur == C_STUR) && mem_ready)
                 || (state_q == S_WB);
  assign pcsrc    = in_exec && ((cls_cur == C_B) || ((cls_cur == C_CBZ) && zero));
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;
  assign retired  = retired_q;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    retired_d = retired_q + {15'd0, pcwrite};
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cls_d = classify(opcode);
        if (cls_d == C_ILL) begin
          state_d = S_HALT;
          fault_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (is_br)
          state_d = S_FETCH;
        else if ((cls_q == C_LDUR) || (cls_q == C_STUR))
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
        else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end else
          wait_d = wait_q + 1'b1;
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 2'b01;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILL;
      fault_q   <= 2'b00;
      retired_q <= 16'd0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction vector table plus reset,
// HALT-hold and mid-MEM reset sequences.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg;
  logic        regwrite, memread, memwrite, halted;
  logic [3:0]  aluop;
  logic [1:0]  signop, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .reg2loc(reg2loc),
    .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .aluop(aluop), .signop(signop), .state(state),
    .halted(halted), .fault(fault), .retired(retired)
  );

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        z;
    int          wt;
    int          cyc;
    logic [8:0]  sig;
    logic        ps;
    int          rw, mr, mw, pw;
    logic [2:0]  st;
    logic [1:0]  flt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting in FETCH (at a sample point) until the next
  // FETCH or HALT, driving mem_ready low for wt MEM cycles and high elsewhere.
  task automatic run_instr(input logic [10:0] op, input logic z, input int wt,
                           output int cyc, output int rw, output int mr, output int mw,
                           output int pw, output logic [8:0] sig, output logic stable,
                           output logic ps, output logic [2:0] end_st, output logic tmo);
    int mcnt;
    logic [8:0] cur;
    cyc = 0; rw = 0; mr = 0; mw = 0; pw = 0; mcnt = 0;
    sig = '0; stable = 1'b1; ps = 1'b0; end_st = 3'd7; tmo = 1'b1;
    opcode = op;
    zero = z;
    for (int k = 0; k < 60; k++) begin
      mem_ready = (state == 3'd3) ? (mcnt >= wt) : 1'b1;
      #1;
      if (k > 0 && (state == 3'd0 || state == 3'd5)) begin
        end_st = state;
        tmo = 1'b0;
        break;
      end
      cur = {reg2loc, alusrc, mem2reg, aluop, signop};
      if (state == 3'd1) sig = cur;
      else if (k > 1 && cur !== sig) stable = 1'b0;
      rw += int'(regwrite);
      mr += int'(memread);
      mw += int'(memwrite);
      pw += int'(pcwrite);
      if (pcwrite) ps = pcsrc;
      if (state == 3'd3) mcnt++;
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic do_reset();
    resetl = 1'b1;
    @(negedge CLK);
    resetl = 1'b0;
    #1;
  endtask

  initial begin
    int cyc, rw, mr, mw, pw, exp_ret, strb;
    logic [8:0] sig;
    logic stable, ps, tmo;
    logic [2:0] end_st;

    //            name     opcode           z  wt  cyc sig           ps   rw mr  mw  pw st    flt
    tbl[0]  = '{"ADD",   11'b10001011000, 0, 0,  4, 9'b000001000, 1'b0, 1, 0,  0, 1, 3'd0, 2'd0};
    tbl[1]  = '{"SUB",   11'b11001011000, 0, 0,  4, 9'b000011000, 1'b0, 1, 0,  0, 1, 3'd0, 2'd0};
    tbl[2]  = '{"AND",   11'b10001010000, 0, 0,  4, 9'b000000000, 1'b0, 1, 0,  0, 1, 3'd0, 2'd0};
    tbl[3]  = '{"ORR",   11'b10101010000, 0, 0,  4, 9'b000000100, 1'b0, 1, 0,  0, 1, 3'd0, 2'd0};
    tbl[4]  = '{"LDUR3", 11'b11111000010, 0, 3,  8, 9'b011001001, 1'b0, 1, 4,  0, 1, 3'd0, 2'd0};
    tbl[5]  = '{"STUR0", 11'b11111000000, 0, 0,  4, 9'b110001001, 1'b0, 0, 0,  1, 1, 3'd0, 2'd0};
    tbl[6]  = '{"STUR2", 11'b11111000000, 0, 2,  6, 9'b110001001, 1'b0, 0, 0,  3, 1, 3'd0, 2'd0};
    tbl[7]  = '{"CBZ1",  11'b10110100101, 1, 0,  3, 9'b100011111, 1'b1, 0, 0,  0, 1, 3'd0, 2'd0};
    tbl[8]  = '{"CBZ0",  11'b10110100010, 0, 0,  3, 9'b100011111, 1'b0, 0, 0,  0, 1, 3'd0, 2'd0};
    tbl[9]  = '{"B",     11'b00010111111, 0, 0,  3, 9'b000001010, 1'b1, 0, 0,  0, 1, 3'd0, 2'd0};
    tbl[10] = '{"MOVZ",  11'b11010010110, 0, 0,  4, 9'b010011100, 1'b0, 1, 0,  0, 1, 3'd0, 2'd0};
    tbl[11] = '{"LDUR0", 11'b11111000010, 0, 0,  5, 9'b011001001, 1'b0, 1, 1,  0, 1, 3'd0, 2'd0};
    tbl[12] = '{"STUR_TO",11'b11111000000,0, 99, 18, 9'b110001001, 1'b0, 0, 0, 15, 0, 3'd5, 2'd2};
    tbl[13] = '{"ILLEGAL",11'h000,        0, 0,  2, 9'b000001000, 1'b0, 0, 0,  0, 0, 3'd5, 2'd1};

    repeat (2) @(negedge CLK);
    resetl = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_memwrite", 32'(memwrite), 32'd0);
    exp_ret = 0;

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].wt, cyc, rw, mr, mw, pw, sig, stable, ps, end_st, tmo);
      exp_ret = (exp_ret + tbl[i].pw) & 16'hFFFF;
      chk({tbl[i].name, "_bound"}, 32'(tmo), 32'd0);
      chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      chk({tbl[i].name, "_ctrl"}, 32'(sig), 32'(tbl[i].sig));
      chk({tbl[i].name, "_ctrl_stable"}, 32'(stable), 32'd1);
      chk({tbl[i].name, "_strobes"}, {8'(rw), 8'(mr), 8'(mw), 8'(pw)},
          {8'(tbl[i].rw), 8'(tbl[i].mr), 8'(tbl[i].mw), 8'(tbl[i].pw)});
      if (tbl[i].pw > 0) chk({tbl[i].name, "_pcsrc"}, 32'(ps), 32'(tbl[i].ps));
      chk({tbl[i].name, "_end_state"}, 32'(end_st), 32'(tbl[i].st));
      chk({tbl[i].name, "_fault"}, 32'(fault), 32'(tbl[i].flt));
      chk({tbl[i].name, "_halted"}, 32'(halted), 32'(tbl[i].st == 3'd5));
      chk({tbl[i].name, "_retired"}, 32'(retired), 32'(exp_ret));
      $display("vec %0d %s: cycles=%0d rw=%0d mr=%0d mw=%0d pw=%0d end=%0d fault=%0d retired=%0d",
               i, tbl[i].name, cyc, rw, mr, mw, pw, end_st, fault, retired);
      if (tbl[i].st == 3'd5) begin
        strb = 0;
        for (int k = 0; k < 3; k++) begin
          mem_ready = 1'b1;
          strb += int'(irwrite) + int'(pcwrite) + int'(regwrite) + int'(memread) + int'(memwrite);
          @(negedge CLK);
          #1;
        end
        chk({tbl[i].name, "_halt_hold_state"}, 32'(state), 32'd5);
        chk({tbl[i].name, "_halt_strobes"}, 32'(strb), 32'd0);
        chk({tbl[i].name, "_halt_retired"}, 32'(retired), 32'(exp_ret));
        do_reset();
        exp_ret = 0;
        chk({tbl[i].name, "_post_reset_state"}, 32'(state), 32'd0);
        chk({tbl[i].name, "_post_reset_fault"}, 32'(fault), 32'd0);
        chk({tbl[i].name, "_post_reset_retired"}, 32'(retired), 32'd0);
      end
    end

    // Reset landing in the middle of a stalled store.
    run_instr(11'b10001011000, 1'b0, 0, cyc, rw, mr, mw, pw, sig, stable, ps, end_st, tmo);
    chk("midmem_pre_retired", 32'(retired), 32'd1);
    opcode = 11'b11111000000;
    mem_ready = 1'b0;
    tmo = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (state == 3'd3) begin tmo = 1'b0; break; end
      @(negedge CLK);
      #1;
    end
    chk("midmem_reach_mem", 32'(tmo), 32'd0);
    repeat (2) begin @(negedge CLK); #1; end
    chk("midmem_memwrite_high", 32'(memwrite), 32'd1);
    resetl = 1'b1;
    #1;
    chk("midmem_memwrite_in_reset", 32'(memwrite), 32'd0);
    @(negedge CLK);
    resetl = 1'b0;
    #1;
    chk("midmem_state", 32'(state), 32'd0);
    chk("midmem_fault", 32'(fault), 32'd0);
    chk("midmem_retired", 32'(retired), 32'd0);
    chk("midmem_memwrite", 32'(memwrite), 32'd0);
    $display("midmem reset: state=%0d fault=%0d retired=%0d memwrite=%0d",
             state, fault, retired, memwrite);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
